// File: rtl/part_2_piso_tx.sv
// ---------------------------------------------------------------------------
// part_2_piso_tx
//   Parallel-in / serial-out transmitter. The block accepts a WIDTH-bit word
//   with a valid/ready handshake and shifts it out MSB first, one bit per
//   clock. The sdo_valid flag marks each frame bit and sdo_last marks the LSB.
//   The block can accept the next word during the sdo_last cycle, so
//   back-to-back frames are sent with no idle cycle between them.
//
// Parameters
//   WIDTH      parallel word width in bits (2..32)
//
// Ports
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   upstream presents a word on in_data
//   in_data    in   [WIDTH-1:0] word to serialize
//   in_ready   out  word can be accepted this cycle (combinational)
//   sdo        out  serial data, MSB first (registered)
//   sdo_valid  out  sdo carries a frame bit (registered)
//   sdo_last   out  sdo carries bit 0 of the frame (registered)
// ---------------------------------------------------------------------------
module part_2_piso_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             sdo,
    output logic             sdo_valid,
    output logic             sdo_last
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sdo_q, sdo_d;
    logic             sdo_valid_q, sdo_valid_d;
    logic             sdo_last_q, sdo_last_d;
    logic             accept;

    // in_ready is the only combinational output. sdo_last_q is the registered
    // form of "SHIFT with the counter at 0", so a word can be accepted on the
    // final bit of the current frame. Gating with rst_n keeps in_ready low
    // while reset is held.
    always_comb begin
        in_ready = rst_n & ((state_q == S_IDLE) | sdo_last_q);
        accept   = in_valid & in_ready;
    end

    // State register, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            sdo_q       <= 1'b0;
            sdo_valid_q <= 1'b0;
            sdo_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            sdo_q       <= sdo_d;
            sdo_valid_q <= sdo_valid_d;
            sdo_last_q  <= sdo_last_d;
        end
    end

    // Next-state logic, together with the shift register and bit counter.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_SHIFT;
                    shreg_d = in_data;
                    cnt_d   = CNT_MAX;
                end
            end
            S_SHIFT: begin
                if (accept) begin
                    // A new word loads on the last bit, so the frames run
                    // back to back.
                    shreg_d = in_data;
                    cnt_d   = CNT_MAX;
                end else if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    shreg_d = '0;
                    cnt_d   = '0;
                end else begin
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    cnt_d   = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic. The outputs are computed from the next-state values so
    // that, once registered, they describe the bit held in shreg_q in the
    // same cycle. This gives the frame a latency of one clock, and no input
    // reaches an output without passing through a flop.
    always_comb begin
        sdo_valid_d = (state_d == S_SHIFT);
        sdo_d       = sdo_valid_d & shreg_d[WIDTH-1];
        sdo_last_d  = sdo_valid_d & (cnt_d == '0);
    end

    assign sdo       = sdo_q;
    assign sdo_valid = sdo_valid_q;
    assign sdo_last  = sdo_last_q;

endmodule

// File: doc/part_2_piso_tx.md
PART_2_PISO_TX -- requirements
Module: part_2_piso_tx

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, parallel word width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  upstream presents a word on in_data.
REQ-005 SHALL have port: in_data  input  WIDTH  parallel word to serialize.
REQ-006 SHALL have port: in_ready  output  1  block can accept a word this cycle.
REQ-007 SHALL have port: sdo  output  1  serial data out, MSB first.
REQ-008 SHALL have port: sdo_valid  output  1  sdo carries a valid frame bit this cycle.
REQ-009 SHALL have port: sdo_last  output  1  sdo carries the final (LSB) bit of the frame.

Function
REQ-010 SHALL implement a two-state FSM: IDLE and SHIFT.
REQ-011 SHALL accept a word only on a posedge where in_valid=1 and in_ready=1; in_data SHALL be ignored on all other cycles.
REQ-012 SHALL drive in_ready combinationally: 1 in IDLE; 1 in SHIFT only while sdo_last=1; 0 otherwise.
REQ-013 On acceptance, SHALL load in_data into a WIDTH-bit shift register and a bit counter to WIDTH-1, and enter or stay in SHIFT.
REQ-014 SHALL present in_data[WIDTH-1] on sdo in the cycle after acceptance (latency 1 clock), with sdo_valid=1.
REQ-015 In SHIFT, SHALL shift left by one each clock, so bit WIDTH-1-k of the word appears k cycles after the MSB.
REQ-016 SHALL hold sdo_valid=1 for exactly WIDTH consecutive cycles per accepted word.
REQ-017 SHALL assert sdo_last=1 only in the cycle carrying bit 0; the counter SHALL reach 0 in that same cycle.
REQ-018 When sdo_last=1 and no word is accepted, SHALL return to IDLE on the next posedge.
REQ-019 When sdo_last=1 and a word is accepted, SHALL output the new MSB on the next cycle with no gap (sdo_valid stays 1).
REQ-020 In IDLE, SHALL drive sdo=0, sdo_valid=0 and sdo_last=0.
REQ-021 sdo, sdo_valid and sdo_last SHALL be registered outputs with no combinational path from inputs.
REQ-022 Changes on in_valid or in_data during SHIFT (outside the sdo_last cycle) SHALL NOT affect the frame in progress.

Reset
REQ-023 rst_n=0 SHALL immediately, without a clock edge, force IDLE, clear the shift register and counter, and set sdo=0, sdo_valid=0 and sdo_last=0.
REQ-024 in_ready SHALL be 0 while rst_n=0 and SHALL be 1 in the first cycle after deassertion.
REQ-025 Reset asserted mid-frame SHALL abort the frame; no remaining bits SHALL be emitted after release.
REQ-026 No word SHALL be accepted on a posedge where rst_n=0.

Verification (WIDTH=8)
REQ-027 SHALL cover the single-word case: accept 0xA5 in IDLE -> next 8 cycles sdo=1,0,1,0,0,1,0,1; sdo_valid=1 for 8 cycles; sdo_last=1 on cycle 8 only; then IDLE with sdo_valid=0.
REQ-028 SHALL cover back-to-back words: hold in_valid=1 with 0xFF then 0x00 -> 16 contiguous valid bits (8 ones, 8 zeros); in_ready=1 only in IDLE and on the two sdo_last cycles.
REQ-029 SHALL cover backpressure: in_valid=1 with 0x3C presented mid-frame of 0x81 -> in_ready=0 until the sdo_last cycle; 0x81 is emitted intact; 0x3C follows with no gap.
REQ-030 SHALL cover reset mid-frame: assert rst_n=0 after 3 bits of 0xC3 -> sdo, sdo_valid and sdo_last go to 0 asynchronously; after release, in_ready=1 and no residual bits appear.
REQ-031 SHALL cover ignored data: toggle in_data with in_valid=0 for 10 cycles -> sdo_valid stays 0 and the FSM stays in IDLE.
REQ-032 SHALL cover extreme words: accept 0x01, then 0x80 -> sdo_last coincides with the single 1 bit of 0x01; for 0x80, the 1 bit comes first and sdo_last comes 7 cycles later.
